// File: rtl/uart_pkg.sv
// Shared UART types and constants for the parametrised receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_e;

    localparam int unsigned OVERSAMPLE_RATE = 16;
    localparam int unsigned SAMPLE_T0       = 7;
    localparam int unsigned SAMPLE_T1       = 8;
    localparam int unsigned SAMPLE_T2       = 9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every CYCLES_PER_TICK clocks while enabled.
module uart_baud_tick #(
    parameter int unsigned CYCLES_PER_TICK = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_TICK - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority vote, valid/ready output
// with parity, framing, break and overrun status.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned  CLK_FREQ    = 50_000_000,
    parameter int unsigned  BAUD_RATE   = 115_200,
    parameter int unsigned  DATA_WIDTH  = 8,
    parameter parity_mode_e PARITY_MODE = PARITY_EVEN,
    parameter int unsigned  STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  break_det,
    output logic                  overrun_err
);

    localparam int unsigned CYCLES_PER_TICK = CLK_FREQ / (BAUD_RATE * OVERSAMPLE_RATE);
    localparam logic [3:0]  T_SAMPLE0  = 4'(SAMPLE_T0);
    localparam logic [3:0]  T_SAMPLE1  = 4'(SAMPLE_T1);
    localparam logic [3:0]  T_DECIDE   = 4'(SAMPLE_T2);
    localparam logic [3:0]  T_LAST     = 4'(OVERSAMPLE_RATE - 1);
    localparam logic [3:0]  DATA_BITS  = 4'(DATA_WIDTH);
    localparam logic [3:0]  LAST_STOP  = 4'(STOP_BITS - 1);
    localparam bit          HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    logic                  sync_q, rxs_q, rxs_prev_q;
    rx_state_e             state_q;
    logic [3:0]            tick_idx_q, tick_next, bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q, s0_q, s1_q, ferr_q, stop0_low_q;
    logic                  tick, start_edge, at_s0, at_s1, at_decide, at_end, vote;
    logic                  par_bad, frame_ferr, frame_brk, stop0_low, last_stop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= rxd;
            rxs_q      <= sync_q;
            rxs_prev_q <= rxs_q;
        end
    end

    uart_baud_tick #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_baud_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (start_edge),
        .enable (state_q != StIdle),
        .tick   (tick)
    );

    // Tick events fire on the pulse that advances the in-bit tick index to the named value.
    always_comb begin
        start_edge = (state_q == StIdle) && rxs_prev_q && !rxs_q;
        tick_next  = tick_idx_q + 4'd1;
        at_s0      = tick && (tick_next == T_SAMPLE0);
        at_s1      = tick && (tick_next == T_SAMPLE1);
        at_decide  = tick && (tick_next == T_DECIDE);
        at_end     = tick && (tick_next == T_LAST);
        vote       = majority3(s0_q, s1_q, rxs_q);
        last_stop  = (bit_cnt_q == LAST_STOP);
        stop0_low  = (bit_cnt_q == 4'd0) ? !vote : stop0_low_q;
        frame_ferr = ferr_q || !vote;
        frame_brk  = (shift_q == '0) && !(HAS_PARITY && par_q) && stop0_low;
        par_bad    = 1'b0;
        if (PARITY_MODE == PARITY_EVEN) begin
            par_bad = ^{shift_q, par_q};
        end else if (PARITY_MODE == PARITY_ODD) begin
            par_bad = ~^{shift_q, par_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tick_idx_q  <= 4'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            ferr_q      <= 1'b0;
            stop0_low_q <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (start_edge) begin
                tick_idx_q <= 4'd0;
            end else if (tick) begin
                tick_idx_q <= tick_next;
            end
            if (at_s0) s0_q <= rxs_q;
            if (at_s1) s1_q <= rxs_q;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q     <= StStart;
                        bit_cnt_q   <= 4'd0;
                        ferr_q      <= 1'b0;
                        stop0_low_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (at_decide && vote) begin
                        state_q <= StIdle;
                    end else if (at_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (at_decide) begin
                        shift_q   <= {vote, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    if (at_end && (bit_cnt_q == DATA_BITS)) begin
                        bit_cnt_q <= 4'd0;
                        state_q   <= HAS_PARITY ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (at_decide) begin
                        par_q <= vote;
                    end else if (at_end) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (at_decide) begin
                        ferr_q      <= frame_ferr;
                        stop0_low_q <= stop0_low;
                        if (last_stop) begin
                            // Leave at mid-stop so the next start edge is caught early.
                            state_q <= StIdle;
                            if (!rx_valid || rx_ready) begin
                                rx_data     <= shift_q;
                                rx_valid    <= 1'b1;
                                parity_err  <= par_bad;
                                framing_err <= frame_ferr;
                                break_det   <= frame_brk;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8E1 (CPT 27), 8O2 and 7N1 (CPT 8) instances.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPT_A = 27;
    localparam int CPT_B = 8;
    localparam int BIT_A = 16 * CPT_A;
    localparam int BIT_B = 16 * CPT_B;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic valid_a, perr_a, ferr_a, brk_a, ovr_a;
    logic valid_b, perr_b, ferr_b, brk_b, ovr_b;
    logic valid_c, perr_c, ferr_c, brk_c, ovr_c;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_seen_a = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (ovr_a) ovr_seen_a <= ovr_seen_a + 1;

    uart_rx_cfg #(
        .CLK_FREQ(50_000_000), .BAUD_RATE(115_200), .DATA_WIDTH(8),
        .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1)
    ) u_8e1 (
        .clk(clk), .reset_n(reset_n), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(rdy_a), .parity_err(perr_a), .framing_err(ferr_a), .break_det(brk_a),
        .overrun_err(ovr_a)
    );

    uart_rx_cfg #(
        .CLK_FREQ(14_745_600), .BAUD_RATE(115_200), .DATA_WIDTH(8),
        .PARITY_MODE(PARITY_ODD), .STOP_BITS(2)
    ) u_8o2 (
        .clk(clk), .reset_n(reset_n), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(rdy_b), .parity_err(perr_b), .framing_err(ferr_b), .break_det(brk_b),
        .overrun_err(ovr_b)
    );

    uart_rx_cfg #(
        .CLK_FREQ(14_745_600), .BAUD_RATE(115_200), .DATA_WIDTH(7),
        .PARITY_MODE(PARITY_NONE), .STOP_BITS(1)
    ) u_7n1 (
        .clk(clk), .reset_n(reset_n), .rxd(rxd_c), .rx_data(data_c), .rx_valid(valid_c),
        .rx_ready(rdy_c), .parity_err(perr_c), .framing_err(ferr_c), .break_det(brk_c),
        .overrun_err(ovr_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Start bit, data LSB first, optional parity, stop bits; unused upper bits idle high.
    function automatic logic [15:0] frame_bits(input logic [8:0] data, input int width,
                                               input int has_par, input logic par,
                                               input int nstop, input logic stop_val);
        logic [15:0] b;
        int k;
        b = '1;
        b[0] = 1'b0;
        k = 1;
        for (int i = 0; i < width; i++) begin
            b[k] = data[i];
            k++;
        end
        if (has_par != 0) begin
            b[k] = par;
            k++;
        end
        for (int s = 0; s < nstop; s++) begin
            b[k] = stop_val;
            k++;
        end
        return b;
    endfunction

    // spike_bit selects a bit that gets a one-tick inverted pulse around its tick-8 sample.
    task automatic send_bits(input int which, input int cpt, input logic [15:0] bits,
                             input int nbits, input int spike_bit);
        for (int i = 0; i < nbits; i++) begin
            if (i == spike_bit) begin
                set_line(which, bits[i]);
                idle_clks(8 * cpt - cpt / 2);
                set_line(which, ~bits[i]);
                idle_clks(cpt);
                set_line(which, bits[i]);
                idle_clks(8 * cpt - cpt / 2);
            end else begin
                set_line(which, bits[i]);
                idle_clks(16 * cpt);
            end
        end
    endtask

    task automatic handshake_a();
        rdy_a = 1'b1;
        idle_clks(1);
        rdy_a = 1'b0;
    endtask

    initial begin
        int lat;
        int nv;
        int o0;

        idle_clks(5);
        reset_n = 1'b1;
        idle_clks(5);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_flags", {perr_a, ferr_a, brk_a, ovr_a}, 0);

        // 8E1 0xA5: four ones, even parity bit 0. Latency 10*432 + 9*27 + 3 = 4566.
        lat = 0;
        fork
            send_bits(0, CPT_A, frame_bits(9'h0A5, 8, 1, 1'b0, 1, 1'b1), 11, -1);
            begin
                while (valid_a !== 1'b1 && lat < 6000) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        check("a5_latency", lat, 4566);
        check("a5_valid", valid_a, 1);
        check("a5_data", data_a, 8'hA5);
        check("a5_flags", {perr_a, ferr_a, brk_a}, 0);
        handshake_a();
        check("a5_handshake", valid_a, 0);

        // 8O2 0x3C: four ones, so odd parity needs a 1; a 0 is the wrong bit.
        send_bits(1, CPT_B, frame_bits(9'h03C, 8, 1, 1'b0, 2, 1'b1), 12, -1);
        check("o2_bad_valid", valid_b, 1);
        check("o2_bad_data", data_b, 8'h3C);
        check("o2_bad_perr", perr_b, 1);
        check("o2_bad_ferr", ferr_b, 0);
        rdy_b = 1'b1;
        idle_clks(1);
        rdy_b = 1'b0;
        send_bits(1, CPT_B, frame_bits(9'h03C, 8, 1, 1'b1, 2, 1'b1), 12, -1);
        check("o2_good_valid", valid_b, 1);
        check("o2_good_data", data_b, 8'h3C);
        check("o2_good_perr", perr_b, 0);

        // 7N1: one-tick low glitch must be rejected as a false start.
        set_line(2, 1'b0);
        idle_clks(CPT_B);
        set_line(2, 1'b1);
        nv = 0;
        repeat (10 * BIT_B) begin
            @(negedge clk);
            if (valid_c) nv++;
        end
        check("n1_false_start", nv, 0);
        // Frame index 4 is data bit 3 (a 0 in 0x55); the spike only hits one sample.
        send_bits(2, CPT_B, frame_bits(9'h055, 7, 0, 1'b0, 1, 1'b1), 9, 4);
        check("n1_spike_valid", valid_c, 1);
        check("n1_spike_data", data_c, 7'h55);
        check("n1_spike_flags", {perr_c, ferr_c, brk_c}, 0);

        // 8E1 break: 0x00, parity 0, stop low, line then held low.
        send_bits(0, CPT_A, frame_bits(9'h000, 8, 1, 1'b0, 1, 1'b0), 11, -1);
        check("brk_valid", valid_a, 1);
        check("brk_data", data_a, 0);
        check("brk_flags", {perr_a, ferr_a, brk_a}, 3'b011);
        handshake_a();
        nv = 0;
        repeat (12 * BIT_A) begin
            @(negedge clk);
            if (valid_a) nv++;
        end
        check("brk_no_retrigger", nv, 0);
        set_line(0, 1'b1);
        idle_clks(2 * BIT_A);

        // Overrun: 0x11 then 0x22 back to back with rx_ready low.
        o0 = ovr_seen_a;
        send_bits(0, CPT_A, frame_bits(9'h011, 8, 1, 1'b0, 1, 1'b1), 11, -1);
        check("ovr_first_data", data_a, 8'h11);
        check("ovr_first_pulses", ovr_seen_a - o0, 0);
        send_bits(0, CPT_A, frame_bits(9'h022, 8, 1, 1'b0, 1, 1'b1), 11, -1);
        check("ovr_held_valid", valid_a, 1);
        check("ovr_held_data", data_a, 8'h11);
        check("ovr_pulse_cycles", ovr_seen_a - o0, 1);
        handshake_a();
        check("ovr_handshake", valid_a, 0);

        // Reset for one clock mid data bit 4 of 0x81.
        nv = 0;
        fork
            send_bits(0, CPT_A, frame_bits(9'h081, 8, 1, 1'b0, 1, 1'b1), 11, -1);
            begin
                idle_clks(5 * BIT_A + 8 * CPT_A);
                reset_n = 1'b0;
                idle_clks(1);
                reset_n = 1'b1;
                check("mid_rst_valid", valid_a, 0);
                check("mid_rst_data", data_a, 0);
                check("mid_rst_flags", {perr_a, ferr_a, brk_a, ovr_a}, 0);
                repeat (6 * BIT_A - 8 * CPT_A - 2) begin
                    @(negedge clk);
                    if (valid_a) nv++;
                end
            end
        join
        check("mid_rst_no_delivery", nv, 0);
        // The aborted frame's tail can look like a start; let it play out and drain.
        rdy_a = 1'b1;
        idle_clks(16 * BIT_A);
        rdy_a = 1'b0;
        idle_clks(4);
        check("drain_idle", valid_a, 0);
        send_bits(0, CPT_A, frame_bits(9'h042, 8, 1, 1'b0, 1, 1'b1), 11, -1);
        check("post_rst_valid", valid_a, 1);
        check("post_rst_data", data_a, 8'h42);
        check("post_rst_flags", {perr_a, ferr_a, brk_a}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
